neander_ctrl: RTL and testbench
===============================

Name: neander_ctrl

Overview:
- Control unit for the 16-bit Neander datapath: accumulator, PC, REM, RDM, IR, N/Z flag register and the shared ULA.
- Fetches one-word instructions and decodes IR[15:12]. Drives the datapath load enables, the ULA selector and the memory read/write handshake.
- Sits between the datapath registers and the external word memory, and is the only block that drives selULA.

Parameters:
- ACK_TIMEOUT, 16: max cycles spent waiting for mem_ack before the error state.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leaves IDLE/HALT and begins fetching at the current PC.
- opcode  in  4  IR[15:12] from the datapath.
- n  in  1  registered N flag.
- z  in  1  registered Z flag.
- mem_ack  in  1  memory completion pulse for the current read/write.
- selULA  out  3  ULA operation: 000 add, 001 X|Y, 010 X&Y, 011 ~X, 100 pass X.
- ld_ac  out  1  load AC from ULA result.
- ld_nz  out  1  load N/Z flag register from ULA.
- ld_ir  out  1  load IR from RDM.
- ld_rem  out  1  load REM.
- sel_rem  out  1  REM source: 0 = PC, 1 = IR address field.
- ld_rdm  out  1  load RDM.
- sel_rdm  out  1  RDM source: 0 = memory data, 1 = AC.
- inc_pc  out  1  PC <= PC+1.
- ld_pc  out  1  PC <= IR address field.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request (data = RDM, addr = REM).
- halted  out  1  high in HALT state.
- err  out  1  sticky memory-timeout flag.
- instr_cnt  out  CNT_W  retired instructions, wraps.

Behaviour:
- Reset: state IDLE. All outputs 0 except selULA = 100. instr_cnt = 0, err = 0, timeout counter = 0. Reset mid-handshake abandons the request; mem_rd/mem_wr are low in the next cycle.
- Outputs are Moore-decoded from state, except ld_rdm in read-wait states, which is asserted when mem_ack = 1 (mem_ack qualified combinationally).
- IDLE: start -> F_ADDR.
- F_ADDR: ld_rem = 1, sel_rem = 0 -> F_RD.
- F_RD: mem_rd = 1 until mem_ack. In the ack cycle: ld_rdm = 1, sel_rdm = 0 -> F_IR. An ack in the first cycle (zero-wait memory) is legal.
- F_IR: ld_ir = 1, inc_pc = 1 -> DECODE.
- DECODE: instr_cnt += 1 (wraps at 2^CNT_W). Next state by opcode:
  - 0 NOP -> F_ADDR
  - 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND -> O_ADDR
  - 6 NOT -> EXEC
  - 8 JMP -> JUMP
  - 9 JN -> JUMP if n, else F_ADDR
  - A JZ -> JUMP if z, else F_ADDR
  - F HLT -> HALT
  - 7, B–E -> treated as NOP
  - n/z are sampled in the DECODE cycle.
- O_ADDR: ld_rem = 1, sel_rem = 1 -> S_LD for STA, O_RD otherwise.
- O_RD: same handshake as F_RD; on ack -> EXEC.
- EXEC: ld_ac = 1, ld_nz = 1. selULA: LDA 100, ADD 000, OR 001, AND 010, NOT 011. -> F_ADDR.
- S_LD: ld_rdm = 1, sel_rdm = 1 -> S_WR.
- S_WR: mem_wr = 1 until mem_ack -> F_ADDR.
- JUMP: ld_pc = 1 -> F_ADDR.
- HALT: halted = 1. start -> F_ADDR, resuming at the PC after the HLT.
- Timeout: counter clears on entering F_RD/O_RD/S_WR and counts each non-ack cycle there. On reaching ACK_TIMEOUT -> ERR. ERR: err = 1, all requests low, held until rst; start is ignored.
- mem_ack outside F_RD/O_RD/S_WR is ignored. start outside IDLE/HALT is ignored.
- Latency with zero-wait memory:
  - NOP/JN/JZ not taken: 4 cycles
  - NOT/JMP/taken jump: 5 cycles
  - LDA/ADD/OR/AND/STA: 7 cycles
  - each wait cycle adds 1.

Test Plan:
- rst, start, memory acks same cycle, opcode = 2 (LDA) -> sequence F_ADDR, F_RD, F_IR, DECODE, O_ADDR, O_RD, EXEC. In EXEC: ld_ac = 1, selULA = 100. instr_cnt = 1.
- Opcodes 3, 4, 5, 6 in turn -> in EXEC, selULA = 000, 001, 010, 011 respectively. Opcode 6 never asserts mem_rd after F_RD.
- STA with mem_ack delayed 3 cycles -> mem_wr high exactly 4 cycles. sel_rdm = 1 with ld_rdm in S_LD. Back to F_ADDR afterwards.
- JN with n = 0 -> 4-cycle instruction, ld_pc never asserted. JZ with z = 1 -> JUMP asserts ld_pc for exactly 1 cycle.
- mem_ack withheld in F_RD for 16 cycles -> ERR entered, err = 1, mem_rd = 0. start ignored. rst clears err and returns to IDLE.
- HLT -> halted = 1, no requests. start -> F_ADDR next cycle. Repeat until instr_cnt wraps from FFFF to 0000. rst asserted during O_RD -> IDLE next cycle, mem_rd = 0.

Source files
------------

// File: rtl/neander_ctrl.sv
// neander_ctrl: control unit for the 16-bit Neander datapath.
//
// Fetches one-word instructions, decodes IR[15:12] and sequences the
// datapath (AC, PC, REM, RDM, IR, N/Z) and the shared ULA.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           leave IDLE/HALT and fetch at the current PC
//   opcode          IR[15:12]
//   n, z            registered N/Z flags (sampled in DECODE)
//   mem_ack         completion pulse for the outstanding read/write
//   selULA          ULA op: 000 add, 001 or, 010 and, 011 not, 100 pass X
//   ld_ac, ld_nz    load AC / N,Z from the ULA
//   ld_ir           load IR from RDM
//   ld_rem, sel_rem load REM from PC (0) or IR address field (1)
//   ld_rdm, sel_rdm load RDM from memory data (0) or AC (1)
//   inc_pc, ld_pc   PC <= PC+1 / PC <= IR address field
//   mem_rd, mem_wr  memory requests
//   halted, err     HALT state / sticky memory-timeout flag
//   instr_cnt       retired-instruction counter (wraps)
//   dbg_state       current FSM state encoding, for observation
//
// Memory handshake: mem_rd (or mem_wr) is held high for every cycle of a
// read (write) wait state. The transfer completes in the first cycle in
// which mem_ack is high while the request is high; mem_ack in any other
// cycle is ignored. A zero-wait memory may acknowledge in the first
// request cycle. If no ack arrives within ACK_TIMEOUT cycles the unit
// locks up in ERR until reset.
module neander_ctrl #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             n,
    input  logic             z,
    input  logic             mem_ack,
    output logic [2:0]       selULA,
    output logic             ld_ac,
    output logic             ld_nz,
    output logic             ld_ir,
    output logic             ld_rem,
    output logic             sel_rem,
    output logic             ld_rdm,
    output logic             sel_rdm,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_F_ADDR = 4'd1,
        ST_F_RD   = 4'd2,
        ST_F_IR   = 4'd3,
        ST_DECODE = 4'd4,
        ST_O_ADDR = 4'd5,
        ST_O_RD   = 4'd6,
        ST_EXEC   = 4'd7,
        ST_S_LD   = 4'd8,
        ST_S_WR   = 4'd9,
        ST_JUMP   = 4'd10,
        ST_HALT   = 4'd11,
        ST_ERR    = 4'd12
    } state_t;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tcnt;
    logic          ld_rdm_q;
    logic          waiting;
    logic          timeout;

    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        case (op)
            4'h3:    alu_sel = 3'b000;
            4'h4:    alu_sel = 3'b001;
            4'h5:    alu_sel = 3'b010;
            4'h6:    alu_sel = 3'b011;
            default: alu_sel = 3'b100;
        endcase
    endfunction

    assign waiting   = (state == ST_F_RD) || (state == ST_O_RD) || (state == ST_S_WR);
    // Last tolerated non-ack cycle: one more miss exhausts the budget.
    assign timeout   = (tcnt == TO_LAST);
    assign dbg_state = state;

    // In read-wait states RDM captures memory data in the ack cycle itself,
    // so the ack is qualified combinationally with the registered request.
    assign ld_rdm    = ld_rdm_q | (mem_rd & mem_ack);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_F_ADDR;
            ST_F_ADDR: state_next = ST_F_RD;
            ST_F_RD: begin
                if (mem_ack)      state_next = ST_F_IR;
                else if (timeout) state_next = ST_ERR;
            end
            ST_F_IR:   state_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: state_next = ST_O_ADDR;
                    4'h6:    state_next = ST_EXEC;
                    4'h8:    state_next = ST_JUMP;
                    4'h9:    state_next = n ? ST_JUMP : ST_F_ADDR;
                    4'hA:    state_next = z ? ST_JUMP : ST_F_ADDR;
                    4'hF:    state_next = ST_HALT;
                    default: state_next = ST_F_ADDR; // NOP and unused codes
                endcase
            end
            ST_O_ADDR: state_next = (opcode == 4'h1) ? ST_S_LD : ST_O_RD;
            ST_O_RD: begin
                if (mem_ack)      state_next = ST_EXEC;
                else if (timeout) state_next = ST_ERR;
            end
            ST_EXEC:   state_next = ST_F_ADDR;
            ST_S_LD:   state_next = ST_S_WR;
            ST_S_WR: begin
                if (mem_ack)      state_next = ST_F_ADDR;
                else if (timeout) state_next = ST_ERR;
            end
            ST_JUMP:   state_next = ST_F_ADDR;
            ST_HALT:   if (start) state_next = ST_F_ADDR;
            ST_ERR:    state_next = ST_ERR;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so each one is a clean
    // Moore decode of the state the machine is in during that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            instr_cnt <= '0;
            selULA    <= 3'b100;
            ld_ac     <= 1'b0;
            ld_nz     <= 1'b0;
            ld_ir     <= 1'b0;
            ld_rem    <= 1'b0;
            sel_rem   <= 1'b0;
            ld_rdm_q  <= 1'b0;
            sel_rdm   <= 1'b0;
            inc_pc    <= 1'b0;
            ld_pc     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;

            // Wait states never follow one another directly, so clearing
            // whenever we are outside them restarts the count on entry.
            if (waiting && !mem_ack) tcnt <= tcnt + TW'(1);
            else                     tcnt <= '0;

            if (state == ST_DECODE) instr_cnt <= instr_cnt + CNT_W'(1);

            selULA   <= (state_next == ST_EXEC) ? alu_sel(opcode) : 3'b100;
            ld_ac    <= (state_next == ST_EXEC);
            ld_nz    <= (state_next == ST_EXEC);
            ld_ir    <= (state_next == ST_F_IR);
            inc_pc   <= (state_next == ST_F_IR);
            ld_rem   <= (state_next == ST_F_ADDR) || (state_next == ST_O_ADDR);
            sel_rem  <= (state_next == ST_O_ADDR);
            ld_rdm_q <= (state_next == ST_S_LD);
            sel_rdm  <= (state_next == ST_S_LD);
            ld_pc    <= (state_next == ST_JUMP);
            mem_rd   <= (state_next == ST_F_RD) || (state_next == ST_O_RD);
            mem_wr   <= (state_next == ST_S_WR);
            halted   <= (state_next == ST_HALT);
            err      <= err | (state_next == ST_ERR);
        end
    end

endmodule

// File: tb/tb_neander_ctrl.sv
// Testbench for neander_ctrl. Directed instruction sequences drive the
// control inputs cycle by cycle and push the expected output snapshot for
// each cycle into a queue; an independent monitor pops and compares on
// the falling edge. The counter width is reduced to 8 bits so that a
// wrap of instr_cnt fits in a short run.
module tb_neander_ctrl;

    localparam int CNT_W = 8;
    localparam int W     = 4 + 3 + 13 + CNT_W;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] F_ADDR = 4'd1;
    localparam logic [3:0] F_RD   = 4'd2;
    localparam logic [3:0] F_IR   = 4'd3;
    localparam logic [3:0] DECODE = 4'd4;
    localparam logic [3:0] O_ADDR = 4'd5;
    localparam logic [3:0] O_RD   = 4'd6;
    localparam logic [3:0] EXEC   = 4'd7;
    localparam logic [3:0] S_LD   = 4'd8;
    localparam logic [3:0] S_WR   = 4'd9;
    localparam logic [3:0] JUMP   = 4'd10;
    localparam logic [3:0] HALT   = 4'd11;
    localparam logic [3:0] ERR    = 4'd12;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       opcode;
    logic             n;
    logic             z;
    logic             mem_ack;
    logic [2:0]       selULA;
    logic             ld_ac, ld_nz, ld_ir, ld_rem, sel_rem, ld_rdm, sel_rdm;
    logic             inc_pc, ld_pc, mem_rd, mem_wr, halted, err;
    logic [CNT_W-1:0] instr_cnt;
    logic [3:0]       dbg_state;

    logic [W-1:0]     exp_q[$];
    string            name_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int               checks;
    int               errors;

    neander_ctrl #(.ACK_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .n         (n),
        .z         (z),
        .mem_ack   (mem_ack),
        .selULA    (selULA),
        .ld_ac     (ld_ac),
        .ld_nz     (ld_nz),
        .ld_ir     (ld_ir),
        .ld_rem    (ld_rem),
        .sel_rem   (sel_rem),
        .ld_rdm    (ld_rdm),
        .sel_rdm   (sel_rdm),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halted    (halted),
        .err       (err),
        .instr_cnt (instr_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    // Expected outputs while in state st, per the control-unit output table.
    function automatic logic [W-1:0] exp_vec(input logic [3:0] st, input logic ack,
                                             input logic [2:0] alu);
        exp_vec = {st,
                   (st == EXEC) ? alu : 3'b100,
                   st == EXEC,                                   // ld_ac
                   st == EXEC,                                   // ld_nz
                   st == F_IR,                                   // ld_ir
                   (st == F_ADDR) || (st == O_ADDR),             // ld_rem
                   st == O_ADDR,                                 // sel_rem
                   (((st == F_RD) || (st == O_RD)) && ack) || (st == S_LD), // ld_rdm
                   st == S_LD,                                   // sel_rdm
                   st == F_IR,                                   // inc_pc
                   st == JUMP,                                   // ld_pc
                   (st == F_RD) || (st == O_RD),                 // mem_rd
                   st == S_WR,                                   // mem_wr
                   st == HALT,                                   // halted
                   st == ERR,                                    // err
                   exp_cnt};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge: drives this cycle's inputs, records
    // the expected snapshot for this cycle, then advances one cycle.
    task automatic step(input logic [3:0] st, input logic ack, input logic stt,
                        input logic [2:0] alu, input string nm);
        mem_ack = ack;
        start   = stt;
        exp_q.push_back(exp_vec(st, ack, alu));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic nf, input logic zf,
                             input int wf, input int wo, input logic [2:0] alu,
                             input string nm);
        opcode = op;
        n      = nf;
        z      = zf;
        step(F_ADDR, 1'b0, 1'b0, alu, nm);
        for (int i = 0; i < wf; i++) step(F_RD, 1'b0, 1'b0, alu, nm);
        step(F_RD, 1'b1, 1'b0, alu, nm);
        step(F_IR, 1'b0, 1'b0, alu, nm);
        step(DECODE, 1'b0, 1'b0, alu, nm);
        exp_cnt = exp_cnt + 8'd1;
        case (op)
            4'h1: begin
                step(O_ADDR, 1'b0, 1'b0, alu, nm);
                step(S_LD, 1'b0, 1'b0, alu, nm);
                for (int i = 0; i < wo; i++) step(S_WR, 1'b0, 1'b0, alu, nm);
                step(S_WR, 1'b1, 1'b0, alu, nm);
            end
            4'h2, 4'h3, 4'h4, 4'h5: begin
                step(O_ADDR, 1'b0, 1'b0, alu, nm);
                for (int i = 0; i < wo; i++) step(O_RD, 1'b0, 1'b0, alu, nm);
                step(O_RD, 1'b1, 1'b0, alu, nm);
                step(EXEC, 1'b0, 1'b0, alu, nm);
            end
            4'h6: step(EXEC, 1'b0, 1'b0, alu, nm);
            4'h8: step(JUMP, 1'b0, 1'b0, alu, nm);
            4'h9: if (nf) step(JUMP, 1'b0, 1'b0, alu, nm);
            4'hA: if (zf) step(JUMP, 1'b0, 1'b0, alu, nm);
            4'hF: step(HALT, 1'b0, 1'b0, alu, nm);
            default: ;
        endcase
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] ev;
        string        nm;
        if (exp_q.size() > 0) begin
            act = {dbg_state, selULA, ld_ac, ld_nz, ld_ir, ld_rem, sel_rem, ld_rdm,
                   sel_rdm, inc_pc, ld_pc, mem_rd, mem_wr, halted, err, instr_cnt};
            ev  = exp_q.pop_front();
            nm  = name_q.pop_front();
            checks++;
            if (act !== ev) begin
                errors++;
                $display("FAIL %s @%0t: got state=%0d outs=%h, expected state=%0d outs=%h",
                         nm, $time, act[W-1 -: 4], act, ev[W-1 -: 4], ev);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        rst     = 1'b1;
        start   = 1'b0;
        opcode  = 4'h0;
        n       = 1'b0;
        z       = 1'b0;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(IDLE, 1'b1, 1'b0, 3'b100, "reset");   // stray ack ignored in IDLE
        step(IDLE, 1'b0, 1'b1, 3'b100, "start");

        // zero-wait memory unless noted
        run_instr(4'h2, 0, 0, 0, 0, 3'b100, "lda");
        run_instr(4'h3, 0, 0, 0, 0, 3'b000, "add");
        run_instr(4'h4, 0, 0, 0, 0, 3'b001, "or");
        run_instr(4'h5, 0, 0, 0, 0, 3'b010, "and");
        run_instr(4'h6, 0, 0, 0, 0, 3'b011, "not");
        run_instr(4'h1, 0, 0, 0, 3, 3'b100, "sta_wait3");
        run_instr(4'h9, 0, 1, 0, 0, 3'b100, "jn_not_taken");
        run_instr(4'hA, 0, 1, 0, 0, 3'b100, "jz_taken");
        run_instr(4'h9, 1, 0, 0, 0, 3'b100, "jn_taken");
        run_instr(4'hA, 1, 0, 0, 0, 3'b100, "jz_not_taken");
        run_instr(4'h8, 0, 0, 0, 0, 3'b100, "jmp");
        run_instr(4'h0, 0, 0, 0, 0, 3'b100, "nop");
        run_instr(4'h7, 0, 0, 0, 0, 3'b100, "op7_nop");
        run_instr(4'hC, 0, 0, 0, 0, 3'b100, "opc_nop");
        run_instr(4'h3, 0, 0, 2, 1, 3'b000, "add_waits");

        run_instr(4'hF, 0, 0, 0, 0, 3'b100, "hlt");
        step(HALT, 1'b1, 1'b0, 3'b100, "halt_hold");
        step(HALT, 1'b0, 1'b1, 3'b100, "halt_start");

        // enough NOPs to carry instr_cnt through FF -> 00
        for (int i = 0; i < 256; i++) run_instr(4'h0, 0, 0, 0, 0, 3'b100, "nop_wrap");

        // read never acknowledged: 16 waiting cycles, then ERR
        step(F_ADDR, 1'b0, 1'b0, 3'b100, "to_addr");
        for (int i = 0; i < 16; i++) step(F_RD, 1'b0, 1'b0, 3'b100, "to_wait");
        step(ERR, 1'b0, 1'b1, 3'b100, "err_start");
        step(ERR, 1'b1, 1'b1, 3'b100, "err_hold");
        rst = 1'b1;
        step(ERR, 1'b0, 1'b0, 3'b100, "err_rst");
        rst = 1'b0;
        exp_cnt = '0;
        step(IDLE, 1'b0, 1'b1, 3'b100, "err_cleared");

        // reset in the middle of an operand read
        opcode = 4'h2;
        step(F_ADDR, 1'b0, 1'b0, 3'b100, "mid_rst");
        step(F_RD, 1'b1, 1'b0, 3'b100, "mid_rst");
        step(F_IR, 1'b0, 1'b0, 3'b100, "mid_rst");
        step(DECODE, 1'b0, 1'b0, 3'b100, "mid_rst");
        exp_cnt = exp_cnt + 8'd1;
        step(O_ADDR, 1'b0, 1'b0, 3'b100, "mid_rst");
        step(O_RD, 1'b0, 1'b0, 3'b100, "mid_rst");
        rst = 1'b1;
        step(O_RD, 1'b0, 1'b0, 3'b100, "mid_rst");
        rst = 1'b0;
        exp_cnt = '0;
        step(IDLE, 1'b0, 1'b0, 3'b100, "rst_ord_idle");
        step(IDLE, 1'b1, 1'b0, 3'b100, "rst_ord_idle2");
        mem_ack = 1'b0;

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
